// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I/D cache controllers, the arbiter and main memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int BEAT_BITS = 2
);
    // I-side refill path
    logic                 i_req;
    logic [31:0]          i_addr;
    logic [31:0]          i_rdata;
    logic                 i_rvalid;
    logic                 i_done;
    // D-side refill / write-back path
    logic                 d_req;
    logic                 d_we;
    logic [31:0]          d_addr;
    logic [31:0]          d_wdata;
    logic [31:0]          d_rdata;
    logic                 d_rvalid;
    logic                 d_done;
    // burst progress and main-memory port
    logic [BEAT_BITS-1:0] beat;
    logic                 mem_req;
    logic                 mem_we;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem_rdata;
    logic                 mem_ack;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_rdata, i_rvalid, i_done, d_rdata, d_rvalid, d_done,
               beat, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_rdata, i_rvalid, i_done, d_rdata, d_rvalid, d_done,
               beat, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester main-memory arbiter: one line-sized burst at a time,
// round-robin on ties, beat address generation and done pulses.
module mem_arbiter #(
    parameter int BEAT_BITS = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int BASE_W = 30 - BEAT_BITS;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } state_t;

    state_t               state;
    state_t               state_n;
    logic                 own_d;
    logic                 last_d;
    logic                 we_q;
    logic [BEAT_BITS-1:0] beat_q;
    logic [BASE_W-1:0]    base_q;

    logic                 any_req;
    logic                 grant_d;
    logic                 in_burst;
    logic                 in_done;
    logic                 rd_ack;

    // Word-offset bits never reach the bus; the line base is all that is kept.
    logic                 unused_addr_bits;
    assign unused_addr_bits = ^{bus.i_addr[BEAT_BITS+1:0], bus.d_addr[BEAT_BITS+1:0]};

    // Request arbitration: on a tie the side that was not served last wins.
    always_comb begin
        any_req = bus.i_req | bus.d_req;
        grant_d = bus.d_req & (~bus.i_req | ~last_d);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_n       = state;
        in_burst      = 1'b0;
        in_done       = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_n = BURST;
                end
            end
            BURST: begin
                in_burst = 1'b1;
                if (bus.mem_ack && (beat_q == '1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                in_done = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        rd_ack        = in_burst & ~we_q & bus.mem_ack;
        bus.mem_req   = in_burst;
        bus.mem_we    = in_burst & we_q;
        bus.mem_addr  = in_burst ? {base_q, beat_q, 2'b00} : '0;
        bus.beat      = beat_q;
        bus.i_rvalid  = rd_ack & ~own_d;
        bus.d_rvalid  = rd_ack & own_d;
        bus.i_done    = in_done & ~own_d;
        bus.d_done    = in_done & own_d;
        bus.i_rdata   = bus.mem_rdata;
        bus.d_rdata   = bus.mem_rdata;
        bus.mem_wdata = bus.d_wdata;
    end

    // Burst context: owner, round-robin history, line base, direction, beat.
    // The beat counter wraps to zero on the final ack, so it reads 0 in DONE/IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            own_d  <= 1'b0;
            last_d <= 1'b0;
            we_q   <= 1'b0;
            beat_q <= '0;
            base_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        own_d  <= grant_d;
                        last_d <= grant_d;
                        we_q   <= grant_d & bus.d_we;
                        beat_q <= '0;
                        base_q <= grant_d ? bus.d_addr[31:BEAT_BITS+2]
                                          : bus.i_addr[31:BEAT_BITS+2];
                    end
                end
                BURST: begin
                    if (bus.mem_ack) begin
                        beat_q <= beat_q + BEAT_BITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (WORDS = 4): directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int BB    = 2;
    localparam int WORDS = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.BEAT_BITS(BB)) bus ();

    mem_arbiter #(.BEAT_BITS(BB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {mem_req, mem_we, i_rvalid, d_rvalid, i_done, d_done}
    logic [5:0]  flags;
    logic [39:0] ctl;
    assign flags = {bus.mem_req, bus.mem_we, bus.i_rvalid, bus.d_rvalid, bus.i_done, bus.d_done};
    assign ctl   = {flags, bus.beat, bus.mem_addr};

    function automatic logic [31:0] line_addr(input logic [31:0] a, input int k);
        return (a & ~32'(WORDS * 4 - 1)) + 32'(4 * k);
    endfunction

    task automatic idle_inputs();
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        logic [31:0] w;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            r = $urandom;
            w = $urandom;
            bus.i_req = 1'($urandom); bus.d_req = 1'($urandom); bus.d_we = 1'($urandom);
            bus.i_addr = $urandom; bus.d_addr = $urandom; bus.mem_ack = 1'($urandom);
            bus.mem_rdata = r; bus.d_wdata = w;
            #1;
            n_vec++;
            if (ctl !== 40'd0) begin
                n_err++; $display("FAIL reset_ctl got=%h want=0", ctl);
            end
            n_vec++;
            if (bus.i_rdata !== r || bus.d_rdata !== r || bus.mem_wdata !== w) begin
                n_err++; $display("FAIL reset_pass got=%h/%h/%h want=%h/%h/%h",
                                  bus.i_rdata, bus.d_rdata, bus.mem_wdata, r, r, w);
            end
            @(negedge clk);
        end
        idle_inputs();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_vec++;
            if (ctl !== 40'd0) begin
                n_err++; $display("FAIL post_reset_idle got=%h want=0", ctl);
            end
        end
    endtask

    task automatic test_i_read();
        logic [31:0] a;
        logic [31:0] r;
        for (int t = 0; t < 2; t++) begin
            a = (t == 0) ? 32'h0040_0018 : $urandom;
            @(negedge clk);
            bus.i_req = 1'b1; bus.i_addr = a; bus.mem_ack = 1'b1;
            #1;
            n_vec++;
            if (flags !== 6'b000000) begin
                n_err++; $display("FAIL iread_c0 flags=%b want=000000", flags);
            end
            for (int k = 1; k <= WORDS; k++) begin
                @(negedge clk);
                r = $urandom; bus.mem_rdata = r;
                #1;
                n_vec++;
                if (bus.mem_addr !== line_addr(a, k - 1) || flags !== 6'b101000 || bus.i_rdata !== r) begin
                    n_err++; $display("FAIL iread_beat%0d addr=%h flags=%b rdata=%h want %h/101000/%h",
                                      k, bus.mem_addr, flags, bus.i_rdata, line_addr(a, k - 1), r);
                end
            end
            @(negedge clk);
            bus.i_req = 1'b0;
            #1;
            n_vec++;
            if (flags !== 6'b000010) begin
                n_err++; $display("FAIL iread_done flags=%b want=000010", flags);
            end
            @(negedge clk);
            bus.mem_ack = 1'b0;
            #1;
            n_vec++;
            if (flags !== 6'b000000) begin
                n_err++; $display("FAIL iread_after flags=%b want=000000", flags);
            end
        end
    endtask

    task automatic test_tie();
        logic [1:0] want;
        do_reset();
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_1000;
        bus.d_req = 1'b1; bus.d_addr = 32'h0000_2000; bus.d_we = 1'b0;
        bus.mem_ack = 1'b1;
        for (int g = 0; g < 3; g++) begin
            want = (g == 1) ? 2'b10 : 2'b01;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk); #1;
                if (bus.i_done || bus.d_done) break;
            end
            n_vec++;
            if ({bus.i_done, bus.d_done} !== want) begin
                n_err++; $display("FAIL tie_grant%0d got={i,d}=%b want=%b", g, {bus.i_done, bus.d_done}, want);
            end
            if (g == 2) begin
                bus.i_req = 1'b0; bus.d_req = 1'b0;
            end else begin
                if (want[0]) bus.d_req = 1'b0; else bus.i_req = 1'b0;
                @(negedge clk);
                bus.i_req = 1'b1; bus.d_req = 1'b1;
            end
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_d_write();
        int          pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        logic [31:0] words [WORDS];
        logic [31:0] a;
        int          n;
        a = 32'h1000_0000;
        for (int i = 0; i < WORDS; i++) words[i] = $urandom;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = a; bus.mem_ack = 1'b0;
        #1;
        n = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            bus.mem_ack = pat[c][0];
            bus.d_wdata = words[n];
            #1;
            n_vec++;
            if (bus.beat !== 2'(n) || bus.mem_addr !== line_addr(a, n) || flags !== 6'b110000
                || bus.mem_wdata !== words[n]) begin
                n_err++; $display("FAIL dwrite_c%0d beat=%0d addr=%h flags=%b wdata=%h want %0d/%h/110000/%h",
                                  c + 1, bus.beat, bus.mem_addr, flags, bus.mem_wdata, n, line_addr(a, n), words[n]);
            end
            if (pat[c] != 0) n++;
        end
        @(negedge clk);
        bus.d_req = 1'b0; bus.mem_ack = 1'b0;
        #1;
        n_vec++;
        if (flags !== 6'b000001) begin
            n_err++; $display("FAIL dwrite_done flags=%b want=000001", flags);
        end
        @(negedge clk);
        bus.d_we = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        a = $urandom;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = a; bus.mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++;
        if (ctl !== 40'd0) begin
            n_err++; $display("FAIL rstmid_now got=%h want=0", ctl);
        end
        bus.d_req = 1'b0;
        @(negedge clk); #1;
        n_vec++;
        if (ctl !== 40'd0) begin
            n_err++; $display("FAIL rstmid_held got=%h want=0", ctl);
        end
        reset = 1'b1;
        @(negedge clk);
        bus.d_req = 1'b1;
        #1;
        n_vec++;
        if (flags !== 6'b000000) begin
            n_err++; $display("FAIL rstmid_idle flags=%b want=000000", flags);
        end
        for (int k = 0; k < WORDS; k++) begin
            @(negedge clk); #1;
            n_vec++;
            if (bus.mem_addr !== line_addr(a, k) || flags !== 6'b100100) begin
                n_err++; $display("FAIL rstmid_beat%0d addr=%h flags=%b want %h/100100",
                                  k, bus.mem_addr, flags, line_addr(a, k));
            end
        end
        @(negedge clk);
        bus.d_req = 1'b0;
        #1;
        n_vec++;
        if (flags !== 6'b000001) begin
            n_err++; $display("FAIL rstmid_done flags=%b want=000001", flags);
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_robust();
        logic [31:0] a;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus.mem_ack = 1'($urandom); bus.mem_rdata = $urandom;
            #1;
            n_vec++;
            if (ctl !== 40'd0) begin
                n_err++; $display("FAIL idle_ack got=%h want=0", ctl);
            end
        end
        a = $urandom;
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = a; bus.mem_ack = 1'b1;
        for (int k = 0; k < WORDS; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.i_req = 1'b0; bus.i_addr = $urandom;
            end
            #1;
            n_vec++;
            if (bus.mem_addr !== line_addr(a, k) || flags !== 6'b101000) begin
                n_err++; $display("FAIL idrop_beat%0d addr=%h flags=%b want %h/101000",
                                  k, bus.mem_addr, flags, line_addr(a, k));
            end
        end
        @(negedge clk); #1;
        n_vec++;
        if (flags !== 6'b000010) begin
            n_err++; $display("FAIL idrop_done flags=%b want=000010", flags);
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
    endtask

    // Reference: each requester is pending from raise until its done; an idle
    // cycle with pending work grants the single requester, or on a tie the one
    // not served last. A burst lasts until four acks, then one done cycle.
    task automatic test_random();
        bit          pend_i, pend_d, last_d, own_d, we, dwe, ack, got;
        logic [31:0] ai, ad, base, r, w;
        int          n;
        logic [5:0]  want;
        do_reset();
        pend_i = 0; pend_d = 0; last_d = 0; dwe = 0; ai = '0; ad = '0;
        for (int b = 0; b < 40; b++) begin
            got = 0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                if (!pend_i && $urandom_range(0, 2) == 0) begin pend_i = 1; ai = $urandom; end
                if (!pend_d && $urandom_range(0, 2) == 0) begin pend_d = 1; ad = $urandom; dwe = 1'($urandom); end
                bus.i_req = pend_i; bus.i_addr = ai; bus.d_req = pend_d; bus.d_addr = ad; bus.d_we = dwe;
                bus.mem_ack = 1'($urandom); bus.mem_rdata = $urandom;
                #1;
                n_vec++;
                if (flags !== 6'b000000) begin
                    n_err++; $display("FAIL rnd_idle b=%0d flags=%b want=000000", b, flags);
                end
                got = pend_i | pend_d;
            end
            if (!got) continue;
            own_d  = pend_d && (!pend_i || !last_d);
            last_d = own_d;
            base   = own_d ? ad : ai;
            we     = own_d && dwe;
            n = 0;
            for (int c = 0; c < 200 && n < WORDS; c++) begin
                @(negedge clk);
                ack = ($urandom_range(0, 3) != 0);
                r = $urandom; w = $urandom;
                if ($urandom_range(0, 3) == 0) begin ai = $urandom; ad = $urandom; dwe = 1'($urandom); end
                if (!pend_i && $urandom_range(0, 4) == 0) pend_i = 1;
                if (!pend_d && $urandom_range(0, 4) == 0) pend_d = 1;
                bus.i_req = pend_i; bus.i_addr = ai; bus.d_req = pend_d; bus.d_addr = ad; bus.d_we = dwe;
                bus.mem_ack = ack; bus.mem_rdata = r; bus.d_wdata = w;
                #1;
                want = {1'b1, we, !own_d && !we && ack, own_d && !we && ack, 2'b00};
                n_vec++;
                if (flags !== want || bus.mem_addr !== line_addr(base, n) || bus.beat !== 2'(n)
                    || bus.i_rdata !== r || bus.d_rdata !== r || bus.mem_wdata !== w) begin
                    n_err++; $display("FAIL rnd_beat b=%0d flags=%b addr=%h beat=%0d want %b/%h/%0d",
                                      b, flags, bus.mem_addr, bus.beat, want, line_addr(base, n), n);
                end
                if (ack) n++;
            end
            n_vec++;
            if (n !== WORDS) begin
                n_err++; $display("FAIL rnd_timeout b=%0d beats=%0d want=%0d", b, n, WORDS);
            end
            @(negedge clk);
            if (own_d) pend_d = 0; else pend_i = 0;
            bus.i_req = pend_i; bus.d_req = pend_d; bus.mem_ack = 1'($urandom);
            #1;
            want = {4'b0000, !own_d, own_d};
            n_vec++;
            if (flags !== want) begin
                n_err++; $display("FAIL rnd_done b=%0d flags=%b want=%b", b, flags, want);
            end
        end
        @(negedge clk);
        idle_inputs();
        repeat (WORDS + 4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_i_read();
        test_tie();
        test_d_write();
        test_reset_mid();
        test_robust();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
